// File: rtl/vc_fifo_umbral.sv
// rtl/vc_fifo_umbral.sv - per-VC FIFO with programmable almost-full/almost-empty thresholds
// Optional sticky overflow/underflow flag: VC_FIFO_ERROR_STICKY_EN.
module vc_fifo_umbral #(
    parameter int BW     = 6,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [BW-1:0]     data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   umbral_alto,
    input  logic [ADDR_W:0]   umbral_bajo,
    output logic [BW-1:0]     data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [BW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= umbral_alto);
    assign almost_empty = (count <= umbral_bajo);

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = pop && !empty;
    assign push_ok = valid_in && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef VC_FIFO_ERROR_STICKY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if ((valid_in && full && !pop) || (pop && empty)) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo_umbral.sv
// tb/tb_vc_fifo_umbral.sv - directed self-checking bench for vc_fifo_umbral
module tb_vc_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [5:0] data_in;
    logic       pop;
    logic [4:0] umbral_alto;
    logic [4:0] umbral_bajo;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       error;

    int passed = 0;
    int total  = 0;
    logic [5:0] q[$];
    logic [5:0] exp_word;

`ifdef VC_FIFO_ERROR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    vc_fifo_umbral #(.BW(6), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        pop         = 1'b0;
        umbral_alto = 5'd14;
        umbral_bajo = 5'd2;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1. reset / idle
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_valid", valid_out, 0);
        check("rst_error", error, 0);
        check("rst_dout", data_out, 0);
        umbral_alto = 5'd0;
        #1;
        check("afull_thr0", almost_full, 1);
        umbral_alto = 5'd14;
        #1;

        // 2. fill 16 words
        for (int i = 1; i <= 16; i++) begin
            valid_in = 1'b1;
            data_in  = 6'(i);
            tick();
            check("fill_count", count, i);
            check("fill_afull", almost_full, (i >= 14) ? 1 : 0);
            check("fill_aempty", almost_empty, (i <= 2) ? 1 : 0);
            check("fill_full", full, (i == 16) ? 1 : 0);
        end

        // 3. overflow push is dropped, then drain in order
        data_in = 6'h3F;
        tick();
        valid_in = 1'b0;
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        check("ovf_error", error, STICKY);
        for (int i = 1; i <= 16; i++) begin
            pop = 1'b1;
            tick();
            check("drain_valid", valid_out, 1);
            check("drain_data", data_out, i);
            check("drain_count", count, 16 - i);
        end
        pop = 1'b0;
        tick();
        check("drain_idle_valid", valid_out, 0);
        check("drain_hold_data", data_out, 6'h10);
        check("drain_empty", empty, 1);

        // 4. simultaneous push/pop at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            data_in  = 6'(6'h30 + i);
            q.push_back(data_in);
            tick();
        end
        check("pp_start_count", count, 3);
        for (int c = 0; c < 20; c++) begin
            valid_in = 1'b1;
            pop      = 1'b1;
            data_in  = 6'(c + 1);
            exp_word = q.pop_front();
            q.push_back(data_in);
            tick();
            check("pp_count", count, 3);
            check("pp_valid", valid_out, 1);
            check("pp_data", data_out, exp_word);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_word = q.pop_front();
            tick();
            check("pp_tail_data", data_out, exp_word);
        end
        pop = 1'b0;
        tick();
        check("pp_end_empty", empty, 1);

        // 5. push+pop on empty: no read-through
        valid_in = 1'b1;
        pop      = 1'b1;
        data_in  = 6'h21;
        tick();
        check("rt_valid", valid_out, 0);
        check("rt_count", count, 1);
        valid_in = 1'b0;
        tick();
        check("rt_pop_valid", valid_out, 1);
        check("rt_pop_data", data_out, 6'h21);
        check("rt_pop_count", count, 0);
        pop = 1'b0;

        // 6. sticky error on underflow, then reset mid-burst
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        check("err_after_rst", error, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("udf_valid", valid_out, 0);
        check("udf_error", error, STICKY);
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            data_in  = 6'(6'h20 + i);
            tick();
        end
        valid_in = 1'b0;
        check("burst_error", error, STICKY);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("burst_count", count, 9);
        check("burst_valid", valid_out, 1);
        check("burst_data", data_out, 6'h20);
        reset = 1'b1;
        #1;
        check("async_count", count, 0);
        check("async_valid", valid_out, 0);
        check("async_error", error, 0);
        check("async_empty", empty, 1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
